// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso4 serial frame transmitter.
// Frame on the line: start bit, WIDTH data bits LSB-first, stop bit.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // The start bit is the opposite of the resting line level, so the receiver sees an edge.
  function automatic logic start_bit(input logic idle_level);
    return ~idle_level;
  endfunction

  function automatic logic stop_bit(input logic idle_level);
    return idle_level;
  endfunction

  function automatic int frame_len(input int width);
    return width + 2;
  endfunction

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Data-bit index counter for piso4: synchronous clear, count enable,
// terminal count when the index reaches WIDTH-1.
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Holds at terminal count so the index can never wrap inside a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/piso4.sv
// Parallel-in serial-out frame transmitter with valid/ready intake.
// Every output is registered from the decoded next state.
module piso4
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_sout,
  output logic             o_sout_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic START_BIT = start_bit(IDLE_LEVEL);
  localparam logic STOP_BIT  = stop_bit(IDLE_LEVEL);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;

  logic r_in_ready;
  logic r_sout;
  logic r_sout_valid;
  logic r_busy;
  logic r_done;

  logic w_accept;
  logic w_cnt_tc;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_load;
  logic w_shift;

  logic w_in_ready_nxt;
  logic w_sout_nxt;
  logic w_sout_valid_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  // Ready is a register, so in_valid never reaches in_ready combinationally.
  assign w_accept = i_in_valid && r_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_DATA;
      ST_DATA:  if (w_cnt_tc) w_state_nxt = ST_STOP;
      ST_STOP:  w_state_nxt = w_accept ? ST_START : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from the next state so the registered line matches the state it enters.
  always_comb begin
    w_in_ready_nxt   = 1'b0;
    w_sout_nxt       = IDLE_LEVEL;
    w_sout_valid_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_in_ready_nxt = 1'b1;
      end
      ST_START: begin
        w_sout_nxt       = START_BIT;
        w_sout_valid_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
      end
      ST_DATA: begin
        w_sout_nxt       = r_shreg[0];
        w_sout_valid_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
      end
      ST_STOP: begin
        w_in_ready_nxt   = 1'b1;
        w_sout_nxt       = STOP_BIT;
        w_sout_valid_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
        w_done_nxt       = 1'b1;
      end
      default: begin
        w_in_ready_nxt = 1'b1;
      end
    endcase
  end

  assign w_load    = w_accept;
  assign w_shift   = (w_state_nxt == ST_DATA);
  assign w_cnt_clr = (r_state == ST_START);
  assign w_cnt_en  = (r_state == ST_DATA);

  // Load and shift never coincide: an accept always leads into START.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= i_in;
    end else if (w_shift) begin
      r_shreg <= r_shreg >> 1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready   <= 1'b0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_cnt_tc)
  );

  assign o_in_ready   = r_in_ready;
  assign o_sout       = r_sout;
  assign o_sout_valid = r_sout_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_piso4.sv
// Scoreboard bench for piso4: default instance checked bit-by-bit against
// queued frames, plus WIDTH=1 and WIDTH=8 instances with a low idle line.
module tb_piso4;

  logic clk;
  logic rst_n;

  logic [3:0] in4;
  logic       v4;
  logic       ready4, sout4, sv4, busy4, done4;

  logic [0:0] in1;
  logic       v1;
  logic       ready1, sout1, sv1, busy1, done1;

  logic [7:0] in8;
  logic       v8;
  logic       ready8, sout8, sv8, busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {expected sout, expected done} for one valid line cycle.
  logic [1:0] q[$];
  int run_len = 0;
  int max_run = 0;

  piso4 u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in         (in4),
    .i_in_valid   (v4),
    .o_in_ready   (ready4),
    .o_sout       (sout4),
    .o_sout_valid (sv4),
    .o_busy       (busy4),
    .o_done       (done4)
  );

  piso4 #(.WIDTH(1), .IDLE_LEVEL(1'b0)) u_dut_w1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in         (in1),
    .i_in_valid   (v1),
    .o_in_ready   (ready1),
    .o_sout       (sout1),
    .o_sout_valid (sv1),
    .o_busy       (busy1),
    .o_done       (done1)
  );

  piso4 #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut_w8 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in         (in8),
    .i_in_valid   (v8),
    .o_in_ready   (ready8),
    .o_sout       (sout8),
    .o_sout_valid (sv8),
    .o_busy       (busy8),
    .o_done       (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] w);
    q.push_back({1'b0, 1'b0});
    for (int i = 0; i < 4; i++) q.push_back({w[i], 1'b0});
    q.push_back({1'b1, 1'b1});
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [3:0] w, input bit hold);
    int n;
    in4 = w;
    v4  = 1'b1;
    n   = 0;
    while (!ready4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", ready4, 1);
    push_frame(w);
    @(negedge clk);
    if (!hold) v4 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (sv4) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (q.size() == 0) begin
        check("unexpected_bit", sv4, 0);
      end else begin
        e = q.pop_front();
        check("sout", sout4, e[1]);
        check("done", done4, e[0]);
        check("busy_frame", busy4, 1);
      end
    end else begin
      run_len = 0;
      check("idle_line", sout4, 1);
      check("idle_done", done4, 0);
      check("idle_busy", busy4, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d errors", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [7:0]  w8;
    int          len;

    rst_n = 1'b0;
    in4 = 4'b1010;
    v4  = 1'b1;
    in1 = 1'b0;
    v1  = 1'b0;
    in8 = 8'h00;
    v8  = 1'b0;

    // Reset held with a word offered: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      check("rst_sout", sout4, 1);
      check("rst_valid", sv4, 0);
      check("rst_ready", ready4, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready4, 1);
    send(4'b1010, 0);
    drain();

    send(4'b0011, 0);
    drain();

    // Back-to-back: second word presented while the first is in flight.
    send(4'b0101, 1);
    send(4'b1110, 0);
    drain();
    check("b2b_run", max_run, 12);

    // Input changes while busy must not disturb the captured word.
    send(4'b1000, 0);
    @(negedge clk);
    in4 = 4'b1111;
    v4  = 1'b1;
    check("ready_busy", ready4, 0);
    @(negedge clk);
    check("ready_busy2", ready4, 0);
    @(negedge clk);
    v4 = 1'b0;
    drain();

    // Reset during data bit 2: frame abandoned immediately.
    send(4'b1100, 0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_sout", sout4, 1);
    check("async_busy", busy4, 0);
    check("async_valid", sv4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b0001, 0);
    drain();

    // WIDTH=8, idle low.
    check("w8_idle_pre", sout8, 0);
    w8  = 8'hA5;
    in8 = w8;
    v8  = 1'b1;
    check("w8_ready", ready8, 1);
    @(negedge clk);
    v8  = 1'b0;
    cap = '0;
    len = 0;
    for (int n = 0; n < 30; n++) begin
      if (sv8) begin
        if (len < 16) cap[len] = sout8;
        len++;
      end else if (len > 0) begin
        break;
      end
      @(negedge clk);
    end
    check("w8_len", len, 10);
    check("w8_start", cap[0], 1);
    check("w8_stop", cap[9], 0);
    for (int i = 0; i < 8; i++) check("w8_data", cap[1+i], w8[i]);
    check("w8_idle_post", sout8, 0);

    // WIDTH=1, idle low.
    check("w1_idle_pre", sout1, 0);
    in1 = 1'b1;
    v1  = 1'b1;
    check("w1_ready", ready1, 1);
    @(negedge clk);
    v1  = 1'b0;
    cap = '0;
    len = 0;
    for (int n = 0; n < 30; n++) begin
      if (sv1) begin
        if (len < 16) cap[len] = sout1;
        len++;
      end else if (len > 0) begin
        break;
      end
      @(negedge clk);
    end
    check("w1_len", len, 3);
    check("w1_start", cap[0], 1);
    check("w1_data", cap[1], 1);
    check("w1_stop", cap[2], 0);
    check("w1_idle_post", sout1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso4.md
# piso4

Parallel-in, serial-out frame transmitter. It is the read-out counterpart to the team's 4-bit load register: it accepts a parallel word through a valid/ready handshake and shifts it onto a single line as start bit, data LSB-first, then stop bit. It sits between a register bank and a one-wire link or a downstream serial receiver.

## Interface
- WIDTH, 4, data word width (≥1)
- IDLE_LEVEL, 1'b1, `sout` level when no frame is in flight; start bit = ~IDLE_LEVEL, stop bit = IDLE_LEVEL
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- in  input  WIDTH  parallel word, sampled on accept
- in_valid  input  1  `in` holds a word to send
- in_ready  output  1  block can accept a word this cycle
- sout  output  1  serial line, registered
- sout_valid  output  1  high while `sout` carries start, data or stop bit
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse during the stop-bit cycle

## Operation
- Accept: `in_valid && in_ready` at a rising edge captures `in` into a WIDTH-bit shift register.
- FSM states and transitions:
  - IDLE: on accept, go to START.
  - START: go to DATA, with the bit counter cleared to 0.
  - DATA: shift one bit per cycle; after the bit with counter = WIDTH-1, go to STOP.
  - STOP: on accept, go to START (back-to-back frames); otherwise go to IDLE.
- Output per state:
  - IDLE: `sout` = IDLE_LEVEL, `sout_valid` = 0.
  - START: `sout` = ~IDLE_LEVEL.
  - DATA: `sout` = shreg[0], then shift right.
  - STOP: `sout` = IDLE_LEVEL, `done` = 1.
- in_ready = 1 in IDLE and STOP, 0 otherwise. `in` and `in_valid` are ignored while in_ready = 0; no word is lost or duplicated.
- Bit counter width is $clog2(WIDTH) with a minimum of 1. It never wraps inside a frame.
- Reset (async assert, any state): state = IDLE, shreg = 0, counter = 0, sout = IDLE_LEVEL, sout_valid = 0, busy = 0, done = 0. The in-flight frame is abandoned and in_ready = 1 on the first edge after deassert.
- Simultaneous accept and STOP: the stop bit is still driven for its full cycle, and the new START follows immediately.

## Timing
- Word accepted at edge k: START on `sout` in cycle k+1, data bit i in cycle k+2+i, stop bit in cycle k+2+WIDTH.
- Frame length is WIDTH+2 cycles (6 for the default). Sustained throughput is one word per WIDTH+2 cycles with no idle gap.
- All outputs are registered. in_ready is a function of registered state only, with no combinational path from in_valid.
- Deassertion of reset is synchronised externally; the block adds no reset synchroniser.

## Structure
- Shared package piso_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), 2 bits;
  - the START_BIT and STOP_BIT constants derived from IDLE_LEVEL;
  - the frame-length function WIDTH+2.
- One sub-module, bit_counter: clear, enable, terminal-count output at WIDTH-1, same async active-low reset.
- Shift register and FSM live in the top module.

## Test plan
- Reset while in_valid = 1, in = 4'b1010. Required: sout = 1, sout_valid = 0, in_ready = 0 while reset = 0; then in_ready = 1 on release and the word is accepted.
- Single word 4'b0011, accepted at edge k. Required: sout = 0,1,1,0,0,1 in cycles k+1..k+6, done high only in cycle k+6, then IDLE with sout = 1.
- Back-to-back: in_valid held high with 4'b0101 then 4'b1110 (second presented in STOP). Required: 12 contiguous valid cycles with line 0,1,0,1,0,1,0,0,1,1,1,1, and no idle bit between frames.
- in changed to 4'b1111 mid-frame while busy (in_ready = 0). Required: the transmitted data stays the originally captured 4'b1000 → bits 0,0,0,1.
- Reset asserted during data bit 2 of 4'b1100. Required: sout returns to 1 immediately (async), busy = 0, no done pulse; next frame 4'b0001 is sent correctly.
- Parameter sweep WIDTH = 1 and WIDTH = 8 with IDLE_LEVEL = 0. Required: frame lengths 3 and 10, start bit = 1, stop bit = 0, idle line = 0.
